// File: rtl/store_buffer_mq.sv
// store_buffer_mq: circular store buffer between the MEM stage and the data cache.
// It holds committed stores with per-byte strobes and forwards bytes to loads.
// A drain request starts when occupancy reaches DRAIN_THRESHOLD.
// The head entry drains through a valid/ready handshake.
// An exception flush discards every entry.
// Optional build macro: SB_COALESCE_EN. When it is defined, a store to the same
// word as the youngest entry merges into that entry.
module store_buffer_mq #(
  parameter int ENTRY_COUNT     = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DRAIN_THRESHOLD = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enq_valid,
  output logic                               enq_ready,
  input  logic [ADDR_W-1:0]                  enq_addr,
  input  logic [DATA_W-1:0]                  enq_data,
  input  logic [DATA_W/8-1:0]                enq_wstrb,
  output logic                               deq_valid,
  input  logic                               deq_ready,
  output logic [ADDR_W-1:0]                  deq_addr,
  output logic [DATA_W-1:0]                  deq_data,
  output logic [DATA_W/8-1:0]                deq_wstrb,
  input  logic                               drain_req,
  input  logic [ADDR_W-1:0]                  ld_addr,
  output logic [DATA_W-1:0]                  ld_data,
  output logic [DATA_W/8-1:0]                ld_hit_mask,
  input  logic                               flush,
  output logic                               force_drain,
  output logic [$clog2(ENTRY_COUNT+1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);

  localparam int                BYTES    = DATA_W / 8;
  localparam int                PTR_W    = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam int                CNT_W    = $clog2(ENTRY_COUNT + 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ENTRY_COUNT);
  localparam logic [CNT_W-1:0]  THR_CNT  = CNT_W'(DRAIN_THRESHOLD);

  // Clear the byte-offset bits so the address names a whole word.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~OFS_MASK;
  endfunction

  // Expand each byte strobe bit into a full byte of mask.
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [BYTES-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) begin
      m[8*b +: 8] = {8{s[b]}};
    end
    return m;
  endfunction

  // Entry state. The valid bits and pointers are control and take the reset.
  // The payload arrays do not take the reset.
  logic [ENTRY_COUNT-1:0] r_valid;
  logic [ADDR_W-1:0]      r_addr  [ENTRY_COUNT];
  logic [DATA_W-1:0]      r_data  [ENTRY_COUNT];
  logic [BYTES-1:0]       r_wstrb [ENTRY_COUNT];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  logic [ADDR_W-1:0]      w_enq_waddr;
  logic [ADDR_W-1:0]      w_ld_waddr;
  logic [DATA_W-1:0]      w_enq_mask;
  logic [PTR_W-1:0]       w_young;
  logic [PTR_W-1:0]       w_fwd_idx;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_deq_fire;
  logic                   w_enq_fire;
  logic                   w_has_bytes;
  logic                   w_merge_ok;
  logic                   w_merge;
  logic                   w_alloc;

  assign w_enq_waddr = word_align(enq_addr);
  assign w_ld_waddr  = word_align(ld_addr);
  assign w_enq_mask  = strb_to_mask(enq_wstrb);
  assign w_young     = r_tail - PTR_W'(1);

  // Status is decoded from the count register alone.
  // Full and empty are told apart only by count, because the pointers alias.
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign force_drain = (r_count >= THR_CNT);

  // Drain: offer the head when the cache is idle or occupancy forces it.
  assign deq_valid  = !w_empty && (drain_req || force_drain);
  assign w_deq_fire = deq_valid && deq_ready;
  assign deq_addr   = w_empty ? '0 : r_addr[r_head];
  assign deq_data   = w_empty ? '0 : r_data[r_head];
  assign deq_wstrb  = w_empty ? '0 : r_wstrb[r_head];

`ifdef SB_COALESCE_EN
  // A store may merge into the youngest entry when the word matches.
  // Merging is blocked when that entry is the head leaving this cycle.
  assign w_merge_ok = !w_empty && r_valid[w_young] &&
                      (r_addr[w_young] == w_enq_waddr) &&
                      !((w_young == r_head) && w_deq_fire);
  assign enq_ready  = !w_full || w_merge_ok;
`else
  assign w_merge_ok = 1'b0;
  assign enq_ready  = !w_full;
`endif

  // An accepted store with no bytes enabled is dropped without allocating.
  assign w_enq_fire  = enq_valid && enq_ready;
  assign w_has_bytes = |enq_wstrb;
  assign w_merge     = w_enq_fire && w_has_bytes && w_merge_ok;
  assign w_alloc     = w_enq_fire && w_has_bytes && !w_merge_ok;

  // Control state: valid bits, pointers and occupancy. A flush wins over a same-cycle enqueue or dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq_fire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_deq_fire);
    end
  end

  // Payload writes: a new entry stores only its strobed bytes; a merge overlays them onto the youngest entry.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (w_alloc) begin
        r_addr[r_tail]  <= w_enq_waddr;
        r_data[r_tail]  <= enq_data & w_enq_mask;
        r_wstrb[r_tail] <= enq_wstrb;
      end
      if (w_merge) begin
        r_data[w_young]  <= (r_data[w_young] & ~w_enq_mask) | (enq_data & w_enq_mask);
        r_wstrb[w_young] <= r_wstrb[w_young] | enq_wstrb;
      end
    end
  end

  // Load forwarding: walk entries from oldest to youngest so the youngest matching byte wins.
  always_comb begin
    ld_data     = '0;
    ld_hit_mask = '0;
    w_fwd_idx   = r_head;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      w_fwd_idx = r_head + PTR_W'(i);
      if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx] == w_ld_waddr)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (r_wstrb[w_fwd_idx][b]) begin
            ld_data[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
            ld_hit_mask[b]    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_mq.sv
// Bench for store_buffer_mq: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the buffer.
module tb_store_buffer_mq;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BY = 4;
  localparam int TH = 6;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic [BY-1:0] enq_wstrb;
  logic          deq_valid, deq_ready;
  logic [AW-1:0] deq_addr;
  logic [DW-1:0] deq_data;
  logic [BY-1:0] deq_wstrb;
  logic          drain_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [BY-1:0] ld_hit_mask;
  logic          flush, force_drain, full, empty;
  logic [CW-1:0] count;

  store_buffer_mq #(.ENTRY_COUNT(N), .ADDR_W(AW), .DATA_W(DW), .DRAIN_THRESHOLD(TH)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_wstrb(enq_wstrb),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_addr(deq_addr),
    .deq_data(deq_data), .deq_wstrb(deq_wstrb),
    .drain_req(drain_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_hit_mask(ld_hit_mask), .flush(flush), .force_drain(force_drain),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BY-1:0] s;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic          e_rdy, e_dv, e_fd, e_full, e_empty, e_mrg;
  logic [CW-1:0] e_cnt;
  logic [AW-1:0] e_daddr;
  logic [DW-1:0] e_ddata, e_ld;
  logic [BY-1:0] e_dstrb, e_hm;

  function automatic logic [AW-1:0] wa(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic logic [DW-1:0] msk(input logic [BY-1:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Expected outputs given the model contents and the current inputs.
  task automatic model_expect();
    int n;
    n       = q.size();
    e_cnt   = CW'(n);
    e_full  = (n == N);
    e_empty = (n == 0);
    e_fd    = (n >= TH);
    e_dv    = (n > 0) && (drain_req || e_fd);
    e_daddr = (n > 0) ? q[0].a : '0;
    e_ddata = (n > 0) ? q[0].d : '0;
    e_dstrb = (n > 0) ? q[0].s : '0;
`ifdef SB_COALESCE_EN
    e_mrg = (n > 0) && (q[n-1].a == wa(enq_addr)) && !(n == 1 && e_dv && deq_ready);
`else
    e_mrg = 1'b0;
`endif
    e_rdy = !e_full || e_mrg;
    e_ld  = '0;
    e_hm  = '0;
    for (int i = 0; i < n; i++) begin
      if (q[i].a == wa(ld_addr)) begin
        for (int b = 0; b < BY; b++) begin
          if (q[i].s[b]) begin
            e_ld[8*b +: 8] = q[i].d[8*b +: 8];
            e_hm[b]        = 1'b1;
          end
        end
      end
    end
  endtask

  // Apply one clock edge to the model using the pre-edge expectations.
  task automatic model_apply();
    int   n;
    bit   deq, enq, mrg;
    ent_t e;
    n = q.size();
    if (flush) begin
      q.delete();
    end else begin
      deq = e_dv && deq_ready;
      enq = enq_valid && e_rdy && (enq_wstrb != '0);
      mrg = enq && e_mrg;
      if (mrg) begin
        e = q[n-1];
        for (int b = 0; b < BY; b++)
          if (enq_wstrb[b]) e.d[8*b +: 8] = enq_data[8*b +: 8];
        e.s = e.s | enq_wstrb;
        q[n-1] = e;
      end
      if (deq) void'(q.pop_front());
      if (enq && !mrg) begin
        e.a = wa(enq_addr);
        e.d = enq_data & msk(enq_wstrb);
        e.s = enq_wstrb;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    model_expect();
    model_apply();
    @(posedge clock);
    #1;
  endtask

  task automatic do_enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] s);
    enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_wstrb = s;
    tick();
    enq_valid = 1'b0; enq_wstrb = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++;
      $display("FAIL reset_status count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    checks++; if (enq_ready !== 1'b1 || deq_valid !== 1'b0 || force_drain !== 1'b0) begin errors++;
      $display("FAIL reset_hs enq_ready=%b deq_valid=%b force_drain=%b want 1/0/0", enq_ready, deq_valid, force_drain); end
    checks++; if (ld_hit_mask !== 4'b0 || ld_data !== 32'h0 || deq_addr !== 32'h0 || deq_data !== 32'h0 || deq_wstrb !== 4'h0) begin errors++;
      $display("FAIL reset_data hm=%b ld=%h da=%h dd=%h ds=%b want zeros", ld_hit_mask, ld_data, deq_addr, deq_data, deq_wstrb); end
    reset = 1'b0;
    @(posedge clock); #1;
    // Mid-stream reset with three entries held.
    do_enq(32'h80, 32'h1, 4'hF);
    do_enq(32'h84, 32'h2, 4'hF);
    do_enq(32'h88, 32'h3, 4'hF);
    ld_addr = 32'h84; drain_req = 1'b1; #1;
    checks++; if (count !== 4'd3 || ld_hit_mask !== 4'hF) begin errors++;
      $display("FAIL prereset_fill count=%0d hm=%b want 3/1111", count, ld_hit_mask); end
    reset = 1'b1; q.delete();
    @(posedge clock); #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 1'b0 || ld_hit_mask !== 4'b0) begin errors++;
      $display("FAIL midreset count=%0d empty=%b dv=%b hm=%b want 0/1/0/0", count, empty, deq_valid, ld_hit_mask); end
    reset = 1'b0; drain_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_drain_threshold();
    for (int k = 0; k < 6; k++) begin
      do_enq(32'h100 + 32'(4*k), $urandom, 4'hF);
      if (k == 4) begin
        #1;
        checks++; if (force_drain !== 1'b0 || deq_valid !== 1'b0) begin errors++;
          $display("FAIL below_threshold fd=%b dv=%b want 0/0", force_drain, deq_valid); end
      end
    end
    #1;
    checks++; if (force_drain !== 1'b1 || deq_valid !== 1'b1 || count !== 4'd6 || deq_addr !== 32'h100) begin errors++;
      $display("FAIL at_threshold fd=%b dv=%b count=%0d da=%h want 1/1/6/100", force_drain, deq_valid, count, deq_addr); end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0; #1;
    checks++; if (count !== 4'd5 || deq_addr !== 32'h104 || force_drain !== 1'b0) begin errors++;
      $display("FAIL after_drain count=%0d da=%h fd=%b want 5/104/0", count, deq_addr, force_drain); end
    do_flush();
  endtask

  task automatic test_full_backpressure();
    for (int k = 0; k < 8; k++) do_enq(32'h500 + 32'(4*k), 32'hB0 + 32'(k), 4'hF);
    enq_valid = 1'b1; enq_addr = 32'h520; enq_data = 32'hCAFE0009; enq_wstrb = 4'hF; #1;
    checks++; if (full !== 1'b1 || enq_ready !== 1'b0 || count !== 4'd8) begin errors++;
      $display("FAIL full_state full=%b rdy=%b count=%0d want 1/0/8", full, enq_ready, count); end
    tick();
    checks++; if (count !== 4'd8) begin errors++;
      $display("FAIL held_store count=%0d want 8", count); end
    deq_ready = 1'b1; #1;
    checks++; if (deq_valid !== 1'b1 || enq_ready !== 1'b0) begin errors++;
      $display("FAIL no_passthru dv=%b rdy=%b want 1/0", deq_valid, enq_ready); end
    tick();
    deq_ready = 1'b0; #1;
    checks++; if (count !== 4'd7 || enq_ready !== 1'b1) begin errors++;
      $display("FAIL after_deq count=%0d rdy=%b want 7/1", count, enq_ready); end
    tick();
    enq_valid = 1'b0; enq_wstrb = '0; ld_addr = 32'h520; #1;
    checks++; if (count !== 4'd8 || ld_hit_mask !== 4'hF || ld_data !== 32'hCAFE0009 || deq_addr !== 32'h504) begin errors++;
      $display("FAIL held_accepted count=%0d hm=%b ld=%h da=%h want 8/1111/cafe0009/504", count, ld_hit_mask, ld_data, deq_addr); end
    do_flush();
  endtask

  task automatic test_forwarding();
    do_enq(32'h200, 32'h11223344, 4'hF);
    do_enq(32'h202, 32'h00AA0000, 4'b0100);
    ld_addr = 32'h200; #1;
    checks++; if (ld_hit_mask !== 4'hF || ld_data !== 32'h11AA3344) begin errors++;
      $display("FAIL fwd_merge hm=%b ld=%h want 1111/11aa3344", ld_hit_mask, ld_data); end
    ld_addr = 32'h204; #1;
    checks++; if (ld_hit_mask !== 4'h0 || ld_data !== 32'h0) begin errors++;
      $display("FAIL fwd_miss hm=%b ld=%h want 0000/0", ld_hit_mask, ld_data); end
    enq_valid = 1'b1; enq_addr = 32'h208; enq_data = 32'h55667788; enq_wstrb = 4'hF; ld_addr = 32'h20A; #1;
    checks++; if (ld_hit_mask !== 4'h0) begin errors++;
      $display("FAIL fwd_same_cycle hm=%b want 0000", ld_hit_mask); end
    tick();
    enq_valid = 1'b0; enq_wstrb = '0; #1;
    checks++; if (ld_hit_mask !== 4'hF || ld_data !== 32'h55667788) begin errors++;
      $display("FAIL fwd_next_cycle hm=%b ld=%h want 1111/55667788", ld_hit_mask, ld_data); end
    do_flush();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) do_enq(32'h600 + 32'(4*k), $urandom, 4'hF);
    drain_req = 1'b1; deq_ready = 1'b1; flush = 1'b1;
    enq_valid = 1'b1; enq_addr = 32'h700; enq_data = 32'h77; enq_wstrb = 4'hF; #1;
    checks++; if (deq_valid !== 1'b1 || count !== 4'd4) begin errors++;
      $display("FAIL preflush dv=%b count=%0d want 1/4", deq_valid, count); end
    tick();
    flush = 1'b0; enq_valid = 1'b0; enq_wstrb = '0; deq_ready = 1'b0; ld_addr = 32'h700; #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 1'b0 || ld_hit_mask !== 4'h0) begin errors++;
      $display("FAIL flush count=%0d empty=%b dv=%b hm=%b want 0/1/0/0", count, empty, deq_valid, ld_hit_mask); end
    drain_req = 1'b0;
  endtask

  task automatic test_coalesce();
    logic [CW-1:0] x_cnt;
    logic [BY-1:0] x_strb;
    logic [DW-1:0] x_data;
`ifdef SB_COALESCE_EN
    x_cnt = 4'd1; x_strb = 4'b0011; x_data = 32'h00000201;
`else
    x_cnt = 4'd2; x_strb = 4'b0001; x_data = 32'h00000001;
`endif
    do_enq(32'h300, 32'h00000001, 4'b0001);
    do_enq(32'h301, 32'h00000200, 4'b0010);
    #1;
    checks++; if (count !== x_cnt || deq_wstrb !== x_strb || deq_data !== x_data || deq_addr !== 32'h300) begin errors++;
      $display("FAIL coalesce count=%0d ds=%b dd=%h da=%h want %0d/%b/%h/300", count, deq_wstrb, deq_data, deq_addr, x_cnt, x_strb, x_data); end
    do_flush();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_addr  = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      enq_data  = $urandom;
      enq_wstrb = BY'($urandom_range(0, 15));
      drain_req = ($urandom_range(0, 1) == 1);
      deq_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      ld_addr   = 32'h400 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      #1;
      model_expect();
      checks++; if (count !== e_cnt || full !== e_full || empty !== e_empty || force_drain !== e_fd) begin errors++;
        $display("FAIL rnd_status c=%0d count=%0d f=%b e=%b fd=%b want %0d/%b/%b/%b", c, count, full, empty, force_drain, e_cnt, e_full, e_empty, e_fd); end
      checks++; if (enq_ready !== e_rdy || deq_valid !== e_dv) begin errors++;
        $display("FAIL rnd_hs c=%0d rdy=%b dv=%b want %b/%b", c, enq_ready, deq_valid, e_rdy, e_dv); end
      checks++; if (deq_addr !== e_daddr || deq_data !== e_ddata || deq_wstrb !== e_dstrb) begin errors++;
        $display("FAIL rnd_head c=%0d da=%h dd=%h ds=%b want %h/%h/%b", c, deq_addr, deq_data, deq_wstrb, e_daddr, e_ddata, e_dstrb); end
      checks++; if (ld_hit_mask !== e_hm || ld_data !== e_ld) begin errors++;
        $display("FAIL rnd_fwd c=%0d hm=%b ld=%h want %b/%h", c, ld_hit_mask, ld_data, e_hm, e_ld); end
      tick();
    end
    enq_valid = 1'b0; flush = 1'b0; deq_ready = 1'b0; drain_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_wstrb = '0;
    deq_ready = 1'b0; drain_req = 1'b0; ld_addr = '0; flush = 1'b0;
    test_reset();
    test_drain_threshold();
    test_full_backpressure();
    test_forwarding();
    test_flush();
    test_coalesce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
